// File: rtl/score_display_drawer_if.sv
// Score display bus: scan coordinates, frame strobe and score commands
// toward the drawer; pixel result and score status back from it.
//   pixelX/pixelY   current scan coordinate
//   startOfFrame    one-cycle pulse per frame
//   add_valid/add_amount/clear  score commands
//   drawingRequest/RGBout       registered pixel result
//   score_bcd/saturated         registered score status
interface score_display_drawer_if #(
  parameter int DIGITS = 4
);
  logic [10:0]         pixelX;
  logic [10:0]         pixelY;
  logic                startOfFrame;
  logic                add_valid;
  logic [3:0]          add_amount;
  logic                clear;
  logic                drawingRequest;
  logic [7:0]          RGBout;
  logic [4*DIGITS-1:0] score_bcd;
  logic                saturated;

  modport master (
    output pixelX, pixelY, startOfFrame, add_valid, add_amount, clear,
    input  drawingRequest, RGBout, score_bcd, saturated
  );

  modport slave (
    input  pixelX, pixelY, startOfFrame, add_valid, add_amount, clear,
    output drawingRequest, RGBout, score_bcd, saturated
  );
endinterface

// File: rtl/score_display_drawer.sv
// BCD score keeper and on-screen renderer: draws a "SCORE" label followed
// by DIGITS seven-segment style glyphs, highlighting for FLASH_FRAMES
// frames after every score change.
//   clk     sole clock
//   resetN  synchronous, active-high reset
//   bus     score_display_drawer_if slave (scan inputs, commands, pixel out)
module score_display_drawer #(
  parameter int          DIGITS        = 4,
  parameter int          SCALE_SHIFT   = 1,
  parameter int          TOP_LEFT_X    = 16,
  parameter int          TOP_LEFT_Y    = 0,
  parameter int          DIGIT_GAP     = 2,
  parameter int          BLANK_LEADING = 1,
  parameter int          FLASH_FRAMES  = 30,
  parameter logic [7:0]  COLOR         = 8'hFF,
  parameter logic [7:0]  FLASH_COLOR   = 8'hE0
) (
  input logic                   clk,
  input logic                   resetN,
  score_display_drawer_if.slave bus
);

  localparam int unsigned PITCH = 8 + DIGIT_GAP;
  localparam logic [11:0] LBL_X = 12'(TOP_LEFT_X);
  localparam logic [11:0] LBL_Y = 12'(TOP_LEFT_Y);
  localparam logic [11:0] DIG_X = 12'(TOP_LEFT_X + (56 << SCALE_SHIFT));
  localparam logic [4*DIGITS-1:0] NINES = {DIGITS{4'h9}};

  logic [4*DIGITS-1:0] r_score;
  logic [7:0]          r_flash;
  logic                r_draw;
  logic [7:0]          r_rgb;

  logic [3:0]          w_amt;
  logic [3:0]          w_carry;
  logic [4:0]          w_dsum;
  logic [4*DIGITS-1:0] w_sum_score;
  logic [4*DIGITS-1:0] w_next;

  logic [11:0]         w_lrx, w_lry, w_drx;
  logic [10:0]         w_lx, w_ly, w_dx;
  logic [3:0]          w_lcol;
  logic [7:0]          w_lrow8;
  logic                w_lbit;
  logic [2:0]          w_dcol;
  logic [7:0]          w_drow8;
  logic                w_dbit;
  logic [DIGITS-1:0]   w_vis;
  logic                w_any;
  logic                w_px;

  // 8x12 label letters S,C,O,R,E; MSB is the leftmost column.
  function automatic logic [7:0] letter_row(input logic [2:0] k, input logic [3:0] r);
    logic [7:0] v;
    v = '0;
    case (k)
      3'd0: case (r) inside
        4'd0, 4'd10:        v = 8'b01111110;
        4'd1, 4'd9:         v = 8'b11000011;
        4'd2, 4'd3:         v = 8'b11000000;
        4'd4:               v = 8'b01111100;
        4'd5:               v = 8'b00111110;
        [4'd6:4'd8]:        v = 8'b00000011;
        default:            v = '0;
      endcase
      3'd1: case (r) inside
        4'd0, 4'd10:        v = 8'b01111110;
        4'd1, 4'd9:         v = 8'b11000011;
        [4'd2:4'd8]:        v = 8'b11000000;
        default:            v = '0;
      endcase
      3'd2: case (r) inside
        4'd0, 4'd10:        v = 8'b01111110;
        [4'd1:4'd9]:        v = 8'b11000011;
        default:            v = '0;
      endcase
      3'd3: case (r) inside
        4'd0, 4'd4:         v = 8'b11111110;
        [4'd1:4'd3]:        v = 8'b11000011;
        4'd5:               v = 8'b11011000;
        4'd6:               v = 8'b11001100;
        4'd7:               v = 8'b11000110;
        [4'd8:4'd10]:       v = 8'b11000011;
        default:            v = '0;
      endcase
      3'd4: case (r) inside
        4'd0, 4'd10:        v = 8'b11111111;
        4'd5:               v = 8'b11111100;
        [4'd1:4'd9]:        v = 8'b11000000;
        default:            v = '0;
      endcase
      default: v = '0;
    endcase
    return v;
  endfunction

  // 8x16 digit glyphs built from seven 2-pixel-thick segments.
  function automatic logic [7:0] glyph_row(input logic [3:0] d, input logic [3:0] r);
    logic [6:0] s; // {a,b,c,d,e,f,g}
    logic [7:0] v;
    case (d)
      4'd0: s = 7'b1111110;
      4'd1: s = 7'b0110000;
      4'd2: s = 7'b1101101;
      4'd3: s = 7'b1111001;
      4'd4: s = 7'b0110011;
      4'd5: s = 7'b1011011;
      4'd6: s = 7'b1011111;
      4'd7: s = 7'b1110000;
      4'd8: s = 7'b1111111;
      4'd9: s = 7'b1111011;
      default: s = '0;
    endcase
    v = '0;
    if (s[6] && r <= 4'd1)                 v = v | 8'b01111110;
    if (s[1] && r >= 4'd1 && r <= 4'd7)    v = v | 8'b11000000;
    if (s[5] && r >= 4'd1 && r <= 4'd7)    v = v | 8'b00000011;
    if (s[0] && (r == 4'd7 || r == 4'd8))  v = v | 8'b01111110;
    if (s[2] && r >= 4'd8 && r <= 4'd14)   v = v | 8'b11000000;
    if (s[4] && r >= 4'd8 && r <= 4'd14)   v = v | 8'b00000011;
    if (s[3] && r >= 4'd14)                v = v | 8'b01111110;
    return v;
  endfunction

  // Ripple BCD add; a carry out of the top digit pins the score at all nines.
  always_comb begin
    w_amt       = (bus.add_amount > 4'd9) ? 4'd9 : bus.add_amount;
    w_carry     = w_amt;
    w_dsum      = '0;
    w_sum_score = r_score;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      w_dsum = {1'b0, r_score[4*i +: 4]} + {1'b0, w_carry};
      if (w_dsum > 5'd9) begin
        w_sum_score[4*i +: 4] = 4'(w_dsum - 5'd10);
        w_carry = 4'd1;
      end else begin
        w_sum_score[4*i +: 4] = w_dsum[3:0];
        w_carry = 4'd0;
      end
    end
    if (w_carry != 4'd0) w_sum_score = NINES;

    w_next = r_score;
    if (bus.clear)          w_next = '0;
    else if (bus.add_valid) w_next = w_sum_score;
  end

  // A digit is visible if it or any more-significant digit is nonzero.
  always_comb begin
    w_any = 1'b0;
    w_vis = '0;
    for (int unsigned j = 0; j < DIGITS; j++) begin
      w_any = w_any | (r_score[4*(DIGITS-1-j) +: 4] != 4'd0);
      w_vis[DIGITS-1-j] = (BLANK_LEADING == 0) || (j == DIGITS-1) || w_any;
    end
  end

  // 12-bit differences: bit 11 set means the pixel lies left of / above an origin.
  always_comb begin
    w_lrx = {1'b0, bus.pixelX} - LBL_X;
    w_lry = {1'b0, bus.pixelY} - LBL_Y;
    w_drx = {1'b0, bus.pixelX} - DIG_X;
    w_lx  = w_lrx[10:0] >> SCALE_SHIFT;
    w_ly  = w_lry[10:0] >> SCALE_SHIFT;
    w_dx  = w_drx[10:0] >> SCALE_SHIFT;

    w_lcol  = '0;
    w_lrow8 = '0;
    w_lbit  = 1'b0;
    // Label is five 10-column cells with the 8-wide letter in columns 1..8.
    if (!w_lrx[11] && !w_lry[11] && w_lx < 11'd50 && w_ly < 11'd12) begin
      for (int unsigned k = 0; k < 5; k++) begin
        if (w_lx >= 11'(k*10) && w_lx < 11'(k*10 + 10)) begin
          w_lcol  = 4'(w_lx - 11'(k*10));
          w_lrow8 = letter_row(3'(k), w_ly[3:0]);
          if (w_lcol >= 4'd1 && w_lcol <= 4'd8)
            w_lbit = w_lrow8[3'(4'd8 - w_lcol)];
        end
      end
    end

    w_dcol  = '0;
    w_drow8 = '0;
    w_dbit  = 1'b0;
    // Cell i counts from the left, so it shows digit DIGITS-1-i.
    if (!w_drx[11] && !w_lry[11] && w_ly < 11'd16) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (w_dx >= 11'(i*PITCH) && w_dx < 11'(i*PITCH + 8)) begin
          w_dcol  = 3'(w_dx - 11'(i*PITCH));
          w_drow8 = glyph_row(r_score[4*(DIGITS-1-i) +: 4], w_ly[3:0]);
          w_dbit  = w_vis[DIGITS-1-i] & w_drow8[3'(3'd7 - w_dcol)];
        end
      end
    end

    w_px = w_lbit | w_dbit;
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      r_score <= '0;
      r_flash <= '0;
      r_draw  <= 1'b0;
      r_rgb   <= '0;
    end else begin
      r_score <= w_next;
      if (w_next != r_score)
        r_flash <= 8'(FLASH_FRAMES);
      else if (bus.startOfFrame && r_flash != 8'd0)
        r_flash <= r_flash - 8'd1;
      r_draw <= w_px;
      r_rgb  <= w_px ? ((r_flash != 8'd0) ? FLASH_COLOR : COLOR) : 8'h00;
    end
  end

  assign bus.score_bcd      = r_score;
  assign bus.saturated      = (r_score == NINES);
  assign bus.drawingRequest = r_draw;
  assign bus.RGBout         = r_rgb;

endmodule

// File: tb/tb_score_display_drawer.sv
module tb_score_display_drawer;

  logic clk;
  logic resetN;
  int   n_pass;
  int   n_total;

  score_display_drawer_if #(.DIGITS(4)) bus ();

  score_display_drawer #(
    .DIGITS(4), .SCALE_SHIFT(1), .TOP_LEFT_X(16), .TOP_LEFT_Y(0),
    .DIGIT_GAP(2), .BLANK_LEADING(1), .FLASH_FRAMES(30),
    .COLOR(8'hFF), .FLASH_COLOR(8'hE0)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic add(input logic [3:0] a);
    bus.add_valid  = 1'b1;
    bus.add_amount = a;
    step();
    bus.add_valid  = 1'b0;
  endtask

  task automatic sof();
    bus.startOfFrame = 1'b1;
    step();
    bus.startOfFrame = 1'b0;
  endtask

  task automatic px(input int x, input int y);
    bus.pixelX = 11'(x);
    bus.pixelY = 11'(y);
    step();
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    resetN = 1'b1;
    bus.pixelX = 11'd2000;
    bus.pixelY = 11'd2000;
    bus.startOfFrame = 1'b0;
    bus.add_valid = 1'b0;
    bus.add_amount = 4'd0;
    bus.clear = 1'b0;
    step();
    step();
    check("rst_score", 32'(bus.score_bcd), 32'h0000);
    check("rst_sat", 32'(bus.saturated), 32'd0);
    check("rst_draw", 32'(bus.drawingRequest), 32'd0);
    check("rst_rgb", 32'(bus.RGBout), 32'h00);
    resetN = 1'b0;
    step();

    // Label: (16,4) -> bit[2][0]=0, (18,4) -> bit[2][1]=1
    px(16, 4);
    check("lbl_16_4", 32'(bus.drawingRequest), 32'd0);
    bus.pixelX = 11'd18;
    #1;
    check("lbl_latency", 32'(bus.drawingRequest), 32'd0);
    step();
    check("lbl_18_4", 32'(bus.drawingRequest), 32'd1);
    check("lbl_18_4_rgb", 32'(bus.RGBout), 32'hFF);
    px(15, 4);
    check("lbl_left_of_origin", 32'(bus.drawingRequest), 32'd0);
    px(116, 4);
    check("lbl_past_width", 32'(bus.drawingRequest), 32'd0);
    px(190, 0);
    check("ones_zero_drawn", 32'(bus.drawingRequest), 32'd1);

    // Clamp and clear
    add(4'd12);
    check("clamp_12", 32'(bus.score_bcd), 32'h0009);
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    check("clear", 32'(bus.score_bcd), 32'h0000);

    // 7 + 5 with reload during active flash
    add(4'd7);
    check("add7", 32'(bus.score_bcd), 32'h0007);
    repeat (5) sof();
    add(4'd5);
    check("add5", 32'(bus.score_bcd), 32'h0012);
    bus.pixelX = 11'd18;
    bus.pixelY = 11'd4;
    for (int k = 1; k <= 31; k++) begin
      step();
      check($sformatf("flash_before_sof%0d", k), 32'(bus.RGBout),
            (k <= 30) ? 32'hE0 : 32'hFF);
      sof();
    end

    // Adding zero changes nothing and does not flash
    add(4'd0);
    check("add0_score", 32'(bus.score_bcd), 32'h0012);
    step();
    check("add0_noflash", 32'(bus.RGBout), 32'hFF);

    // Score 0012: tens '1' right column drawn, hundreds blanked
    px(180, 4);
    check("tens_1_col6", 32'(bus.drawingRequest), 32'd1);
    px(150, 4);
    check("hund_blank", 32'(bus.drawingRequest), 32'd0);

    // Score 0007 digit row scan
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    add(4'd7);
    check("score7", 32'(bus.score_bcd), 32'h0007);
    px(190, 0);
    check("ones_7_col1", 32'(bus.drawingRequest), 32'd1);
    px(188, 0);
    check("ones_7_col0", 32'(bus.drawingRequest), 32'd0);
    px(130, 0);
    check("thou_blank", 32'(bus.drawingRequest), 32'd0);
    px(150, 0);
    check("hund_blank0", 32'(bus.drawingRequest), 32'd0);
    px(170, 0);
    check("tens_blank", 32'(bus.drawingRequest), 32'd0);
    px(204, 0);
    check("gap_after_ones", 32'(bus.drawingRequest), 32'd0);

    // Clear wins over add, from 0042
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    add(4'd9); add(4'd9); add(4'd9); add(4'd9); add(4'd6);
    check("score42", 32'(bus.score_bcd), 32'h0042);
    repeat (30) sof();
    px(18, 4);
    check("flash_expired42", 32'(bus.RGBout), 32'hFF);
    bus.clear = 1'b1;
    bus.add_valid = 1'b1;
    bus.add_amount = 4'd3;
    step();
    bus.clear = 1'b0;
    bus.add_valid = 1'b0;
    check("clear_beats_add", 32'(bus.score_bcd), 32'h0000);
    step();
    check("clear_flash", 32'(bus.RGBout), 32'hE0);

    // Saturation
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    repeat (1110) add(4'd9);
    add(4'd5);
    check("score9995", 32'(bus.score_bcd), 32'h9995);
    check("sat_9995", 32'(bus.saturated), 32'd0);
    add(4'd9);
    check("score9999", 32'(bus.score_bcd), 32'h9999);
    check("sat_9999", 32'(bus.saturated), 32'd1);
    px(130, 0);
    check("thou_9_drawn", 32'(bus.drawingRequest), 32'd1);
    repeat (30) sof();
    px(18, 4);
    check("flash_expired_sat", 32'(bus.RGBout), 32'hFF);
    add(4'd9);
    check("sat_hold", 32'(bus.score_bcd), 32'h9999);
    step();
    check("sat_noflash", 32'(bus.RGBout), 32'hFF);

    // Reset with a simultaneous add
    resetN = 1'b1;
    bus.add_valid = 1'b1;
    bus.add_amount = 4'd5;
    step();
    bus.add_valid = 1'b0;
    check("rst2_score", 32'(bus.score_bcd), 32'h0000);
    check("rst2_sat", 32'(bus.saturated), 32'd0);
    check("rst2_draw", 32'(bus.drawingRequest), 32'd0);
    check("rst2_rgb", 32'(bus.RGBout), 32'h00);
    resetN = 1'b0;
    step();
    check("post_rst_draw", 32'(bus.drawingRequest), 32'd1);
    check("post_rst_rgb", 32'(bus.RGBout), 32'hFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
